// File: rtl/twos_complement_pkg.sv
// Shared constants and the WIDTH-generic modular negation used by the datapath.
// Operands up to 64 bits wide are supported; callers zero-extend and truncate.
package twos_complement_pkg;
  localparam int TC_WIDTH_DEFAULT = 8;
  localparam int TC_MAX_W         = 64;

  typedef struct packed {
    logic [TC_MAX_W-1:0] val;
    logic                ovf;
  } tc_neg_t;

  function automatic logic [TC_MAX_W-1:0] tc_most_neg(input int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  // A shift by 64 yields 0, so the subtraction gives all ones at full width.
  function automatic logic [TC_MAX_W-1:0] tc_mask(input int unsigned w);
    return (64'(1) << w) - 64'd1;
  endfunction

  function automatic tc_neg_t negate(input int unsigned w, input logic [TC_MAX_W-1:0] a);
    tc_neg_t             r;
    logic [TC_MAX_W-1:0] m;
    m     = tc_mask(w);
    r.val = (~a + 64'd1) & m;
    r.ovf = ((a & m) == tc_most_neg(w));
    return r;
  endfunction
endpackage

// File: rtl/twos_complement_if.sv
// Valid/ready handshake bundle for the negator: operand in, result plus flags out.
interface twos_complement_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic             ovf;
  logic             zero;

  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, b, ovf, zero);
  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, b, ovf, zero);
endinterface

// File: rtl/twos_complement_core.sv
// Combinational negation of one operand with overflow and zero flags.
// TWOS_COMPLEMENT_SAT_EN selects saturation of the most negative input.
module twos_complement_core
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b_next,
  output logic             ovf_next,
  output logic             zero_next
);
  tc_neg_t neg;

  assign neg       = negate(WIDTH, 64'(a));
  assign ovf_next  = neg.ovf;
  assign zero_next = (a == '0);

`ifdef TWOS_COMPLEMENT_SAT_EN
  assign b_next = neg.ovf ? {1'b0, {(WIDTH-1){1'b1}}} : neg.val[WIDTH-1:0];
`else
  assign b_next = neg.val[WIDTH-1:0];
`endif

  // Upper bits of the 64-bit helper result are zero by construction.
  generate
    if (WIDTH < TC_MAX_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^neg.val[TC_MAX_W-1:WIDTH];
    end
  endgenerate
endmodule

// File: rtl/twos_complement.sv
// Registered two's-complement negator with valid/ready on both sides.
// Build option: TWOS_COMPLEMENT_SAT_EN (saturating overflow, see core).
module twos_complement
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  twos_complement_if.slave   bus
);
  logic [WIDTH-1:0] b_next, b_q;
  logic             ovf_next, ovf_q;
  logic             zero_next, zero_q;
  logic [1:0]       vld_pipe;

  twos_complement_core #(.WIDTH(WIDTH)) u_core (
    .a         (bus.a),
    .b_next    (b_next),
    .ovf_next  (ovf_next),
    .zero_next (zero_next)
  );

  // vld_pipe[0] is the input transfer, vld_pipe[1] the held result.
  assign bus.in_ready = !vld_pipe[1] || bus.out_ready;
  assign vld_pipe[0]  = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      b_q         <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (vld_pipe[0]) begin
      vld_pipe[1] <= 1'b1;
      b_q         <= b_next;
      ovf_q       <= ovf_next;
      zero_q      <= zero_next;
    end else if (bus.out_ready) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  assign bus.out_valid = vld_pipe[1];
  assign bus.b         = b_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_twos_complement.sv
// Directed plus random checks of the registered negator against an integer model.
module tb_twos_complement;
  localparam int W    = 8;
  localparam int HALF = 1 << (W - 1);
  localparam int FULL = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic         exp_v;
  logic [W-1:0] exp_b;
  logic         exp_o, exp_z;

  twos_complement_if #(.WIDTH(W)) tif ();

  twos_complement #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  always #5 clk = ~clk;

  // Reference: negate the signed integer value, then fold back into W bits.
  function automatic logic [W+1:0] ref_neg(input logic [W-1:0] a);
    int   av, nv;
    logic o;
    av = (int'(a) >= HALF) ? int'(a) - FULL : int'(a);
    nv = -av;
    o  = (nv >= HALF);
`ifdef TWOS_COMPLEMENT_SAT_EN
    if (o) nv = HALF - 1;
`endif
    nv = (nv + FULL) % FULL;
    return {W'(nv), o, (av == 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] a);
    logic [W+1:0] r;
    r = ref_neg(a);
    check({tag, "_v"},    32'(tif.out_valid), 32'd1);
    check({tag, "_b"},    32'(tif.b),         32'(r[W+1:2]));
    check({tag, "_ovf"},  32'(tif.ovf),       32'(r[1]));
    check({tag, "_zero"}, 32'(tif.zero),      32'(r[0]));
  endtask

  task automatic send(input logic [W-1:0] a);
    tif.in_valid  = 1'b1;
    tif.a         = a;
    tif.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W+1:0] r;
    rst_n = 1'b0;
    tif.in_valid = 1'b0;
    tif.a = '0;
    tif.out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", 32'(tif.out_valid), 32'd0);
    check("rst_b",     32'(tif.b),         32'd0);
    check("rst_ovf",   32'(tif.ovf),       32'd0);
    check("rst_zero",  32'(tif.zero),      32'd0);
    check("rst_rdy",   32'(tif.in_ready),  32'd1);
    rst_n = 1'b1;

    send(8'h19); check_out("a25", 8'h19);  check("a25_const", 32'(tif.b), 32'hE7);
    send(8'hE7); check_out("am25", 8'hE7); check("am25_const", 32'(tif.b), 32'h19);
    send(8'h00); check_out("a0", 8'h00);   check("a0_zero", 32'(tif.zero), 32'd1);
    send(8'h80); check_out("amin", 8'h80); check("amin_ovf", 32'(tif.ovf), 32'd1);
`ifdef TWOS_COMPLEMENT_SAT_EN
    check("amin_const", 32'(tif.b), 32'h7F);
`else
    check("amin_const", 32'(tif.b), 32'h80);
`endif

    // Back-to-back stream, then backpressure with a changing held operand.
    send(8'd1); check("s1", 32'(tif.b), 32'hFF);
    send(8'd2); check("s2", 32'(tif.b), 32'hFE); check("s2_v", 32'(tif.out_valid), 32'd1);
    send(8'd3); check("s3", 32'(tif.b), 32'hFD); check("s3_v", 32'(tif.out_valid), 32'd1);
    tif.out_ready = 1'b0;
    tif.a = 8'd55;
    #1 check("bp_rdy", 32'(tif.in_ready), 32'd0);
    @(posedge clk); #1;
    tif.a = 8'd77;
    @(posedge clk); #1;
    check("bp_hold_b", 32'(tif.b),         32'hFD);
    check("bp_hold_v", 32'(tif.out_valid), 32'd1);
    tif.out_ready = 1'b1;
    #1 check("bp_rdy_up", 32'(tif.in_ready), 32'd1);
    @(posedge clk); #1;
    check_out("bp_new", 8'd77);
    tif.in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain_v", 32'(tif.out_valid), 32'd0);
    check("drain_b", 32'(tif.b),         32'(ref_neg(8'd77) >> 2));

    // Asynchronous reset while a result is held under backpressure.
    tif.in_valid = 1'b1; tif.a = 8'h80; tif.out_ready = 1'b0;
    @(posedge clk); #2;
    tif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_v",    32'(tif.out_valid), 32'd0);
    check("arst_b",    32'(tif.b),         32'd0);
    check("arst_ovf",  32'(tif.ovf),       32'd0);
    check("arst_zero", 32'(tif.zero),      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'd127); check("a127", 32'(tif.b), 32'h81);
    tif.in_valid = 1'b0;
    @(posedge clk); #1;

    // Random traffic against a scoreboard of the held result.
    exp_v = 1'b0;
    r = ref_neg(8'd127);
    {exp_b, exp_o, exp_z} = r;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] av;
      logic         iv, ordy, rdy;
      case ($urandom_range(0, 7))
        0:       av = 8'h80;
        1:       av = 8'h00;
        2:       av = 8'h7F;
        default: av = W'($urandom);
      endcase
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      tif.in_valid = iv; tif.a = av; tif.out_ready = ordy;
      rdy = !exp_v || ordy;
      #1 check("rnd_rdy", 32'(tif.in_ready), 32'(rdy));
      @(posedge clk); #1;
      if (iv && rdy) begin
        exp_v = 1'b1;
        {exp_b, exp_o, exp_z} = ref_neg(av);
      end else if (ordy) begin
        exp_v = 1'b0;
      end
      check("rnd_v",    32'(tif.out_valid), 32'(exp_v));
      check("rnd_b",    32'(tif.b),         32'(exp_b));
      check("rnd_ovf",  32'(tif.ovf),       32'(exp_o));
      check("rnd_zero", 32'(tif.zero),      32'(exp_z));
    end

    // Double negation returns the operand for every non-minimum value.
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] v;
      v = W'(i);
      if (v != 8'h80) check("dbl", 32'(ref_neg(ref_neg(v) >> 2 & 10'hFF) >> 2), 32'(v));
      if (i % 32 == 0) begin
        send(v);
        send(tif.b);
        if (v != 8'h80) check("dbl_dut", 32'(tif.b), 32'(v));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
